// File: rtl/player_sprite_blitter.sv
// Sprite blitter: scans one animation frame out of a sprite ROM and writes the
// opaque, on-screen pixels into a frame buffer at a latched screen position.
module player_sprite_blitter #(
  parameter int         SPRITE_W    = 40,
  parameter int         SPRITE_H    = 64,
  parameter int         NUM_FRAMES  = 5,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [4:0] TRANSPARENT = 5'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [2:0]  anim_frame,
  input  logic        flip,
  output logic [20:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [4:0]  fb_data,
  output logic        busy,
  output logic        done
);

  localparam int CW        = $clog2(SPRITE_W + 1);
  localparam int RW        = $clog2(SPRITE_H + 1);
  localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t        state, state_next;
  logic [9:0]    x_lat, y_lat;
  logic [2:0]    frame_lat, frame_clamped;
  logic          flip_lat;
  logic [CW-1:0] col, col_next;
  logic [RW-1:0] row, row_next;
  logic          last_pix;
  logic [10:0]   sx, sy;
  logic          pipe_valid, pipe_inside;
  logic [18:0]   pipe_addr;
  logic [4:0]    data_hold;

  function automatic logic [20:0] pixel_addr(input logic [2:0] frame, input logic [RW-1:0] r,
                                             input logic [CW-1:0] c, input logic mirror);
    logic [20:0] src;
    src = mirror ? (21'(SPRITE_W - 1) - 21'(c)) : 21'(c);
    return 21'(frame) * 21'(FRAME_PIX) + 21'(r) * 21'(SPRITE_W) + src;
  endfunction

  assign frame_clamped = (int'(anim_frame) >= NUM_FRAMES) ? 3'(NUM_FRAMES - 1) : anim_frame;
  assign last_pix      = (row == RW'(SPRITE_H - 1)) && (col == CW'(SPRITE_W - 1));
  // 11-bit sums keep off-screen pixels from aliasing back onto the screen
  assign sx            = {1'b0, x_lat} + 11'(col);
  assign sy            = {1'b0, y_lat} + 11'(row);

  assign fb_we   = pipe_valid && pipe_inside && (rom_data != TRANSPARENT);
  assign fb_addr = pipe_addr;
  assign fb_data = fb_we ? rom_data : data_hold;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRAW;
      DRAW:    if (last_pix) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    col_next = col + CW'(1);
    row_next = row;
    if (col == CW'(SPRITE_W - 1)) begin
      col_next = '0;
      row_next = row + RW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_lat       <= '0;
      y_lat       <= '0;
      frame_lat   <= '0;
      flip_lat    <= 1'b0;
      row         <= '0;
      col         <= '0;
      rom_addr    <= '0;
      pipe_valid  <= 1'b0;
      pipe_inside <= 1'b0;
      pipe_addr   <= '0;
      data_hold   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // screen-side stage lines up with rom_data, which lags rom_addr by a cycle
      pipe_valid  <= (state == DRAW);
      pipe_inside <= (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
      if (state == DRAW) pipe_addr <= 19'(21'(sy) * 21'(SCREEN_W) + 21'(sx));
      if (fb_we) data_hold <= rom_data;
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: if (start) begin
          x_lat     <= player_x;
          y_lat     <= player_y;
          frame_lat <= frame_clamped;
          flip_lat  <= flip;
          row       <= '0;
          col       <= '0;
          rom_addr  <= pixel_addr(frame_clamped, '0, '0, flip);
        end
        DRAW: if (!last_pix) begin
          row      <= row_next;
          col      <= col_next;
          rom_addr <= pixel_addr(frame_lat, row_next, col_next, flip_lat);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_sprite_blitter.sv
// Scoreboard bench for player_sprite_blitter: a frame-level reference model
// predicts every frame buffer write and the done timing of each draw.
module tb_player_sprite_blitter;

  localparam int W = 40, H = 64, NF = 5, SW = 640, SH = 480;
  localparam int NPIX = W * H;
  localparam int ROM_N = NF * NPIX;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int done_at; int nwr; int lo; int hi; } draw_t;

  logic        Clk = 1'b0;
  logic        Reset, start, flip;
  logic [9:0]  player_x, player_y;
  logic [2:0]  anim_frame;
  logic [20:0] rom_addr;
  logic [4:0]  rom_data;
  logic        fb_we, busy, done;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;

  logic [4:0] rom_mem [ROM_N];
  wr_t   wq[$];
  draw_t dq[$];
  int n_chk = 0, n_fail = 0;
  int neg_cnt = 0, wr_total = 0, wr_base = 0, amin = 0, amax = 0;

  player_sprite_blitter dut (
    .Clk(Clk), .Reset(Reset), .start(start), .player_x(player_x), .player_y(player_y),
    .anim_frame(anim_frame), .flip(flip), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (int'(rom_addr) < ROM_N) rom_data <= rom_mem[rom_addr];
    else                        rom_data <= 5'h1f;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge Clk) begin
    wr_t e;
    draw_t d;
    neg_cnt++;
    if (!busy) begin
      wr_base = wr_total;
      amin = 32'h7fffffff;
      amax = 0;
    end else begin
      if (int'(rom_addr) < amin) amin = int'(rom_addr);
      if (int'(rom_addr) > amax) amax = int'(rom_addr);
    end
    if (fb_we) begin
      wr_total++;
      if (wq.size() == 0) chk("unexpected_fb_we", 1, 0);
      else begin
        e = wq.pop_front();
        chk("fb_addr", int'(fb_addr), e.addr);
        chk("fb_data", int'(fb_data), e.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = dq.pop_front();
        chk("done_cycle", neg_cnt, d.done_at);
        chk("write_count", wr_total - wr_base, d.nwr);
        chk("rom_addr_min", amin, d.lo);
        chk("rom_addr_max", amax, d.hi);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  // Reference model: the whole sprite is walked pixel by pixel from the frame rules.
  task automatic predict(input int x, input int y, input int f, input int fl);
    draw_t d;
    wr_t w;
    int fr, v, sx, sy, src;
    fr = (f >= NF) ? NF - 1 : f;
    d.nwr = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        src = fl ? (W - 1 - c) : c;
        v = int'(rom_mem[fr * NPIX + r * W + src]);
        sx = x + c;
        sy = y + r;
        if (v != 0 && sx < SW && sy < SH) begin
          w.addr = sy * SW + sx;
          w.data = v;
          wq.push_back(w);
          d.nwr++;
        end
      end
    end
    d.done_at = neg_cnt + 1 + NPIX + 2;
    d.lo = fr * NPIX;
    d.hi = fr * NPIX + NPIX - 1;
    dq.push_back(d);
  endtask

  task automatic issue(input int x, input int y, input int f, input int fl);
    @(posedge Clk); #1;
    player_x = 10'(x); player_y = 10'(y); anim_frame = 3'(f); flip = fl[0]; start = 1'b1;
    predict(x, y, f, fl);
    @(posedge Clk); #1;
    start = 1'b0;
    player_x = 10'($urandom); player_y = 10'($urandom);
    anim_frame = 3'($urandom); flip = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < NPIX + 20 && !seen; i++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      wq.delete();
      dq.delete();
    end
    repeat ($urandom_range(1, 3)) @(posedge Clk);
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < ROM_N; i++) begin
      case (mode)
        0:       rom_mem[i] = 5'($urandom_range(1, 31));
        1:       rom_mem[i] = (i % 2 == 1) ? 5'h00 : 5'($urandom_range(1, 31));
        default: rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(1, 31));
      endcase
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge Clk); #1;
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fb_we"}, int'(fb_we), 0);
  endtask

  initial begin
    fill_rom(0);
    Reset = 1'b1; start = 1'b1; flip = 1'b0;
    player_x = '0; player_y = '0; anim_frame = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0; start = 1'b0;
    check_idle_outputs("reset");
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_fb_addr", int'(fb_addr), 0);
    chk("reset_fb_data", int'(fb_data), 0);

    // opaque sprite at origin
    issue(0, 0, 0, 0);
    wait_done();

    // mirrored frame 2 with a marked corner word
    fill_rom(2);
    rom_mem[2 * NPIX + 39] = 5'h07;
    issue(100, 50, 2, 1);
    chk("flip_first_expected", wq[0].addr * 32 + wq[0].data, (50 * SW + 100) * 32 + 7);
    wait_done();

    // clipped at the bottom-right corner
    fill_rom(0);
    issue(620, 450, 1, 0);
    chk("clip_expected_count", dq[0].nwr, 600);
    wait_done();

    // odd addresses transparent
    fill_rom(1);
    issue(10, 20, 3, 0);
    wait_done();

    // reset 100 cycles into the draw aborts it
    fill_rom(2);
    issue(30, 40, 1, 1);
    repeat (99) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wq.delete();
    dq.delete();
    repeat (3) check_idle_outputs("abort");
    issue(200, 100, 0, 0);
    wait_done();

    // second start mid-draw is ignored; frame 7 clamps to the last frame
    issue(300, 200, 7, 0);
    repeat (50) @(posedge Clk);
    #1 start = 1'b1; player_x = 10'd5; player_y = 10'd5; anim_frame = 3'd0; flip = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    wait_done();

    // randomized draws, positions biased toward the screen edges
    for (int k = 0; k < 6; k++) begin
      fill_rom(2);
      issue($urandom_range(0, 660), $urandom_range(0, 500), $urandom_range(0, 7), $urandom_range(0, 1));
      wait_done();
    end

    repeat (4) @(posedge Clk);
    chk("scoreboard_empty", wq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/player_sprite_blitter.md
PLAYER_SPRITE_BLITTER -- requirements
Module: player_sprite_blitter

Interface
REQ-001 Parameter SPRITE_W, default 40: sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 64: sprite height in pixels.
REQ-003 Parameter NUM_FRAMES, default 5: animation frames stored back-to-back in the sprite ROM.
REQ-004 Parameter SCREEN_W, default 640; parameter SCREEN_H, default 480: frame buffer dimensions.
REQ-005 Parameter TRANSPARENT, default 5'h00: palette index that is never written.
REQ-006 Clk  input  1: single clock; all logic on posedge Clk.
REQ-007 Reset  input  1: synchronous, active-high reset.
REQ-008 start  input  1: one-cycle request to draw one sprite.
REQ-009 player_x, player_y  input  10 each: screen position of the sprite's top-left pixel.
REQ-010 anim_frame  input  3: animation frame to draw.
REQ-011 flip  input  1: 1 = mirror horizontally.
REQ-012 rom_addr  output  21: read address to the sprite ROM (1-cycle registered read).
REQ-013 rom_data  input  5: palette index returned by the ROM.
REQ-014 fb_we  output  1: frame buffer write strobe.
REQ-015 fb_addr  output  19: frame buffer address, y*SCREEN_W + x.
REQ-016 fb_data  output  5: palette index to write.
REQ-017 busy  output  1: high from the cycle after an accepted start until done.
REQ-018 done  output  1: one-cycle pulse when the sprite is complete.

Function
REQ-019 FSM states IDLE, DRAW, FLUSH, DONE; transitions IDLE->DRAW on start, DRAW->FLUSH after the last pixel address, FLUSH->DONE after one cycle, DONE->IDLE after one cycle.
REQ-020 On start in IDLE, player_x, player_y, anim_frame and flip are latched; later changes to these inputs do not affect the draw in progress.
REQ-021 start is ignored in DRAW, FLUSH and DONE.
REQ-022 anim_frame >= NUM_FRAMES is clamped to NUM_FRAMES-1 at latch time.
REQ-023 DRAW scans rows 0..SPRITE_H-1 and, within each row, columns 0..SPRITE_W-1, issuing one ROM address per cycle: SPRITE_W*SPRITE_H cycles total (2560 by default).
REQ-024 rom_addr = frame*SPRITE_W*SPRITE_H + row*SPRITE_W + src_col, where src_col = col if flip=0 and SPRITE_W-1-col if flip=1.
REQ-025 Screen coordinate of a pixel = (x_latched + col, y_latched + row); the destination column is never mirrored.
REQ-026 Screen coordinates are pipelined one stage so that they align with rom_data, which arrives one cycle after rom_addr.
REQ-027 fb_we is asserted in the cycle after an address is issued, only if rom_data != TRANSPARENT, screen x < SCREEN_W, and screen y < SCREEN_H.
REQ-028 Coordinate sums use 11 bits so the clipping test is exact; no wrap onto the opposite screen edge is permitted.
REQ-029 FLUSH produces the write for the last pixel; no fb_we occurs in DONE or IDLE.
REQ-030 done pulses in DONE, exactly SPRITE_W*SPRITE_H+2 cycles after the cycle in which start is accepted.
REQ-031 fb_addr and fb_data hold their last values when fb_we=0; their contents are don't-care when fb_we=0.

Reset
REQ-032 Reset has priority over all other inputs; it forces state IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, and clears the latched parameters.
REQ-033 Reset during DRAW or FLUSH aborts the draw; no fb_we is issued in the cycle after Reset is sampled high.
REQ-034 start asserted in the same cycle as Reset is ignored.

Verification
REQ-035 Start at x=0, y=0, frame 0, flip=0, with the ROM fully opaque -> 2560 writes, fb_addr 0..39, 640..679, and so on; done 2562 cycles after start.
REQ-036 Frame 2, flip=1, ROM word 2*2560+39 = 5'h07 -> the first write has fb_addr = y*640 + x and fb_data = 5'h07.
REQ-037 x=620, y=450 -> only columns 0..19 and rows 0..29 are written (600 writes); no write has x >= 640 or y >= 480.
REQ-038 ROM containing TRANSPARENT at every odd address -> exactly 1280 writes; done timing is unchanged.
REQ-039 Reset asserted 100 cycles into DRAW -> fb_we=0 from the next cycle, busy=0, no done pulse; a new start then completes normally.
REQ-040 start pulsed again mid-draw, and anim_frame=7 -> the second start is ignored and frame 4 addresses (10240..12799) are used.
